axi4_burst_addr_gen: RTL and testbench

- Parametrised AXI4 burst beat generator for the slave-side BFM/memory model.
- Accepts AW- or AR-style commands (id, addr, len, size, burst) through a valid/ready port and buffers them in an outstanding-command queue.
- Expands each command into per-beat address, byte-lane strobe, beat index and last flag on a valid/ready output.
- Supports FIXED, INCR and WRAP bursts, flags illegal bursts, and handles any power-of-two data width and queue depth.

---
 rtl/axi4_burst_addr_gen_pkg.sv | 38 +++
 rtl/axi4_burst_addr_gen_cmd_fifo.sv | 68 ++++++
 rtl/axi4_burst_addr_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_axi4_burst_addr_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_burst_addr_gen_pkg.sv
// Shared definitions for the AXI4 burst beat generator.
// Holds the burst and size encodings, the 4 KB page constants, the
// fixed-width part of a queued command and the generator state type.
package axi4_burst_addr_gen_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } axi4_burst_e;

    localparam logic [2:0] SIZE_1B   = 3'd0;
    localparam logic [2:0] SIZE_2B   = 3'd1;
    localparam logic [2:0] SIZE_4B   = 3'd2;
    localparam logic [2:0] SIZE_8B   = 3'd3;
    localparam logic [2:0] SIZE_16B  = 3'd4;
    localparam logic [2:0] SIZE_32B  = 3'd5;
    localparam logic [2:0] SIZE_64B  = 3'd6;
    localparam logic [2:0] SIZE_128B = 3'd7;

    localparam int AXI4_PAGE_BYTES = 4096;
    localparam int AXI4_PAGE_BITS  = 12;

    // Width-independent part of a command; the top wraps it together with
    // its parametrised id and address fields to form the queue payload.
    typedef struct packed {
        logic [7:0]  len;
        logic [2:0]  size;
        axi4_burst_e burst;
    } axi4_burst_ctl_s;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } gen_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen_cmd_fifo.sv
// axi4_cmd_fifo: registered FIFO holding outstanding burst commands.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and payload (ignored when full)
//   pop, pop_data     read request (ignored when empty) and head payload
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
module axi4_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: expands queued AXI4 AW/AR commands into beats.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   cmd_*                command input (valid/ready), queued in axi4_cmd_fifo
//   beat_*               per-beat id, address, lane strobe, index, last, error
//   cmd_count            queue occupancy
//   busy                 a burst is active or commands are waiting
module axi4_burst_addr_gen
    import axi4_burst_addr_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 4,
    parameter int CMD_DEPTH     = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [ID_WIDTH-1:0]            cmd_id,
    input  logic [ADDRESS_WIDTH-1:0]       cmd_addr,
    input  logic [7:0]                     cmd_len,
    input  logic [2:0]                     cmd_size,
    input  logic [1:0]                     cmd_burst,
    output logic                           beat_valid,
    input  logic                           beat_ready,
    output logic [ID_WIDTH-1:0]            beat_id,
    output logic [ADDRESS_WIDTH-1:0]       beat_addr,
    output logic [DATA_WIDTH/8-1:0]        beat_strb,
    output logic [7:0]                     beat_idx,
    output logic                           beat_last,
    output logic                           beat_err,
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
    output logic                           busy
);

    localparam int                       NB        = DATA_WIDTH / 8;
    localparam int                       AW        = ADDRESS_WIDTH;
    localparam int                       EW        = ADDRESS_WIDTH + 16;
    localparam logic [2:0]               MAX_SIZE  = 3'($clog2(NB));
    localparam logic [AW-1:0]            LANE_MASK = AW'(NB - 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [AW-1:0]       addr;
        axi4_burst_ctl_s     ctl;
    } axi4_burst_cmd_s;

    // Lanes from the byte address up to the end of the size-aligned beat.
    function automatic logic [NB-1:0] lane_strb(input logic [AW-1:0] a, input logic [2:0] size);
        logic [AW-1:0] bmask;
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        bmask = (AW'(1) << size) - AW'(1);
        lo    = a & LANE_MASK;
        hi    = ((a & ~bmask) & LANE_MASK) + bmask;
        for (int i = 0; i < NB; i++) begin
            lane_strb[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
        end
    endfunction

    axi4_burst_cmd_s push_data_s;
    axi4_burst_cmd_s head_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            load_s;
    logic            advance_s;

    gen_state_e      state_r;
    gen_state_e      state_nx_s;

    logic [ID_WIDTH-1:0] id_r;
    logic [AW-1:0]       addr_r;
    logic [NB-1:0]       strb_r;
    logic [7:0]          idx_r;
    logic [7:0]          len_r;
    logic [2:0]          size_r;
    axi4_burst_e         burst_r;
    logic                err_r;
    logic                last_r;
    logic [AW-1:0]       wmask_r;

    logic [AW-1:0]       head_bmask_s;
    logic [AW-1:0]       load_wmask_s;
    logic [EW-1:0]       incr_last_s;
    logic                incr_cross_s;
    logic                size_err_s;
    logic                wrap_len_ok_s;
    logic                wrap_unaligned_s;
    logic                load_err_s;
    logic [AW-1:0]       beat_bmask_s;
    logic [AW-1:0]       next_addr_s;

    assign push_data_s = '{id: cmd_id, addr: cmd_addr,
                           ctl: '{len: cmd_len, size: cmd_size, burst: axi4_burst_e'(cmd_burst)}};
    assign push_s      = cmd_valid && !full_s;

    axi4_cmd_fifo #(
        .WIDTH ($bits(axi4_burst_cmd_s)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (load_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (cmd_count)
    );

    assign cmd_ready  = !full_s;
    assign beat_valid = (state_r == ST_ACTIVE);
    assign busy       = (state_r == ST_ACTIVE) || !empty_s;
    assign beat_id    = id_r;
    assign beat_addr  = addr_r;
    assign beat_strb  = strb_r;
    assign beat_idx   = idx_r;
    assign beat_last  = last_r;
    assign beat_err   = err_r;

    // Legality of the queue head, evaluated only when it is loaded.
    assign head_bmask_s     = (AW'(1) << head_s.ctl.size) - AW'(1);
    assign load_wmask_s     = ((AW'(head_s.ctl.len) + AW'(1)) << head_s.ctl.size) - AW'(1);
    // Extra high bits keep a burst running past the top of the address space
    // from aliasing back into the start page.
    assign incr_last_s      = EW'(head_s.addr & ~head_bmask_s)
                            + ((EW'(head_s.ctl.len) + EW'(1)) << head_s.ctl.size) - EW'(1);
    assign incr_cross_s     = (incr_last_s >> AXI4_PAGE_BITS) != (EW'(head_s.addr) >> AXI4_PAGE_BITS);
    assign size_err_s       = head_s.ctl.size > MAX_SIZE;
    assign wrap_len_ok_s    = (head_s.ctl.len == 8'd1) || (head_s.ctl.len == 8'd3)
                           || (head_s.ctl.len == 8'd7) || (head_s.ctl.len == 8'd15);
    assign wrap_unaligned_s = (head_s.addr & head_bmask_s) != AW'(0);

    // Per-burst-type legality of the head command.
    always_comb begin
        load_err_s = 1'b0;
        case (head_s.ctl.burst)
            BURST_FIXED: load_err_s = size_err_s;
            BURST_INCR:  load_err_s = size_err_s || incr_cross_s;
            BURST_WRAP:  load_err_s = size_err_s || !wrap_len_ok_s || wrap_unaligned_s;
            default:     load_err_s = 1'b1;
        endcase
    end

    // Address of the following beat; error bursts stay on the start address.
    assign beat_bmask_s = (AW'(1) << size_r) - AW'(1);
    always_comb begin
        next_addr_s = addr_r;
        if (err_r) begin
            next_addr_s = addr_r;
        end else begin
            case (burst_r)
                BURST_INCR: next_addr_s = (addr_r & ~beat_bmask_s) + beat_bmask_s + AW'(1);
                BURST_WRAP: next_addr_s = (addr_r & ~wmask_r)
                                        | ((addr_r + beat_bmask_s + AW'(1)) & wmask_r);
                default:    next_addr_s = addr_r;
            endcase
        end
    end

    // Generator state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state; a last-beat handshake reloads straight from the queue.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        advance_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_ACTIVE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (beat_ready && last_r) begin
                    if (!empty_s) begin
                        load_s     = 1'b1;
                        state_nx_s = ST_ACTIVE;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else if (beat_ready) begin
                    advance_s = 1'b1;
                end else begin
                    state_nx_s = ST_ACTIVE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Working registers that drive the beat outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_r    <= '0;
            addr_r  <= '0;
            strb_r  <= '0;
            idx_r   <= 8'd0;
            len_r   <= 8'd0;
            size_r  <= 3'd0;
            burst_r <= BURST_FIXED;
            err_r   <= 1'b0;
            last_r  <= 1'b0;
            wmask_r <= '0;
        end else if (load_s) begin
            id_r    <= head_s.id;
            addr_r  <= head_s.addr;
            strb_r  <= load_err_s ? '0 : lane_strb(head_s.addr, head_s.ctl.size);
            idx_r   <= 8'd0;
            len_r   <= head_s.ctl.len;
            size_r  <= head_s.ctl.size;
            burst_r <= head_s.ctl.burst;
            err_r   <= load_err_s;
            last_r  <= (head_s.ctl.len == 8'd0);
            wmask_r <= load_wmask_s;
        end else if (advance_s) begin
            addr_r  <= next_addr_s;
            strb_r  <= err_r ? '0 : lane_strb(next_addr_s, size_r);
            idx_r   <= idx_r + 8'd1;
            last_r  <= ((idx_r + 8'd1) == len_r);
        end
    end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench for axi4_burst_addr_gen (64-bit data, 4-deep queue).
// Expected beats come from a reference model built on the AXI4 burst rules.
module tb_axi4_burst_addr_gen;

    localparam int NB = 8;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [3:0]  beat_id;
    logic [31:0] beat_addr;
    logic [7:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        beat_err;
    logic [2:0]  cmd_count;
    logic        busy;

    axi4_burst_addr_gen #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (64),
        .ID_WIDTH      (4),
        .CMD_DEPTH     (4)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_id    (beat_id),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .beat_err   (beat_err),
        .cmd_count  (cmd_count),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } tcmd_t;

    tcmd_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic tcmd_t mk(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        mk = '{id, addr, len, size, burst};
    endfunction

    // Reference: {valid, id, addr, strb, idx, last, err} for beat n of c.
    function automatic logic [54:0] model_beat(input tcmd_t c, input int n);
        longint unsigned b, a, al, w, lower, last_byte;
        logic            err;
        logic [7:0]      strb;
        int              lo, hi;
        b   = 64'd1 << c.size;
        al  = c.addr - (c.addr % b);
        err = (c.burst == 2'b11) || (b > NB);
        if (c.burst == 2'b10)
            err = err || !(c.len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((c.addr % b) != 0);
        if (c.burst == 2'b01) begin
            last_byte = al + (longint'(c.len) + 1) * b - 1;
            err = err || ((last_byte / 4096) != (c.addr / 4096));
        end
        a = c.addr;
        if (!err && c.burst == 2'b01 && n > 0) a = al + longint'(n) * b;
        if (!err && c.burst == 2'b10) begin
            w     = b * (longint'(c.len) + 1);
            lower = c.addr - (c.addr % w);
            for (int k = 0; k < n; k++) begin
                a = a + b;
                if (a == lower + w) a = lower;
            end
        end
        a    = a % (64'd1 << 32);
        strb = 8'h00;
        if (!err) begin
            lo = int'(a % NB);
            hi = int'(((a - (a % b)) % NB) + b - 1);
            for (int i = 0; i < NB; i++) strb[i] = (i >= lo) && (i <= hi);
        end
        return {1'b1, c.id, a[31:0], strb, 8'(n), (n == int'(c.len)), err};
    endfunction

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        int    r;
        c.id   = 4'($urandom);
        c.addr = $urandom;
        r      = $urandom_range(0, 9);
        c.burst = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        c.size = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
        c.len  = 8'($urandom_range(0, 15));
        if (c.burst == 2'b10) begin
            case ($urandom_range(0, 8))
                0: c.len = 8'd1;
                1, 2: c.len = 8'd3;
                3, 4: c.len = 8'd7;
                5, 6: c.len = 8'd15;
                default: c.len = 8'd2;
            endcase
            if ($urandom_range(0, 7) != 0) c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
        end
        return c;
    endfunction

    task automatic push_cmd(input tcmd_t c);
        logic got;
        got       = 1'b0;
        cmd_id    = c.id;
        cmd_addr  = c.addr;
        cmd_len   = c.len;
        cmd_size  = c.size;
        cmd_burst = c.burst;
        cmd_valid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            got = cmd_ready;
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL push_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end else begin
            exp_q.push_back(c);
        end
    endtask

    task automatic collect_next(input int stall_max);
        tcmd_t       c;
        logic [54:0] exp_t, act_t;
        int          t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL collect: model queue empty, required a pending command");
            return;
        end
        c = exp_q.pop_front();
        for (int n = 0; n <= int'(c.len); n++) begin
            t = 0;
            while (!beat_valid && t < 100) begin @(posedge aclk); #1; t++; end
            exp_t = model_beat(c, n);
            act_t = {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err};
            vectors++;
            if (act_t !== exp_t) begin
                miscompares++;
                $display("FAIL beat id=%0d n=%0d: got %h required %h", c.id, n, act_t, exp_t);
            end
            repeat ($urandom_range(0, stall_max)) begin
                @(posedge aclk); #1;
                act_t = {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err};
                vectors++;
                if (act_t !== exp_t) begin
                    miscompares++;
                    $display("FAIL beat_hold id=%0d n=%0d: got %h required %h", c.id, n, act_t, exp_t);
                end
            end
            beat_ready = 1'b1;
            @(posedge aclk); #1;
            beat_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({beat_valid, cmd_ready, cmd_count, busy, beat_last, beat_err, beat_strb, beat_idx} !==
            {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b ready=%b count=%0d busy=%b last=%b err=%b strb=%h idx=%0d, required 0 1 0 0 0 0 00 0",
                     beat_valid, cmd_ready, cmd_count, busy, beat_last, beat_err, beat_strb, beat_idx);
        end
    endtask

    task automatic test_examples();
        logic [31:0] ex_addr [8] = '{32'h1003, 32'h1004, 32'h1008, 32'h100C,
                                     32'h38, 32'h20, 32'h28, 32'h30};
        logic [7:0]  ex_strb [8] = '{8'h08, 8'hF0, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tcmd_t       cmds [2];
        logic [48:0] act_t, exp_t;
        cmds[0] = mk(4'd1, 32'h1003, 8'd3, 3'd2, 2'b01);
        cmds[1] = mk(4'd2, 32'h38, 8'd3, 3'd3, 2'b10);
        for (int k = 0; k < 2; k++) begin
            push_cmd(cmds[k]);
            void'(exp_q.pop_front());
            vectors++;
            if (beat_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_early: beat_valid=%b one edge after push, required 0", beat_valid);
            end
            @(posedge aclk); #1;
            for (int n = 0; n < 4; n++) begin
                act_t = {beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err};
                exp_t = {1'b1, ex_addr[k*4+n], ex_strb[k*4+n], 8'(n), (n == 3), 1'b0};
                vectors++;
                if (act_t !== exp_t) begin
                    miscompares++;
                    $display("FAIL example%0d beat %0d: got %h required %h", k, n, act_t, exp_t);
                end
                beat_ready = 1'b1;
                @(posedge aclk); #1;
                beat_ready = 1'b0;
            end
            vectors++;
            if ({beat_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL example%0d_end: valid/busy=%b%b, required 00", k, beat_valid, busy);
            end
        end
    endtask

    task automatic test_fixed_and_illegal();
        tcmd_t cmds [5];
        cmds[0] = mk(4'd3, 32'h10, 8'd2, 3'd0, 2'b00);
        cmds[1] = mk(4'd4, 32'h40, 8'd2, 3'd3, 2'b10);
        cmds[2] = mk(4'd5, 32'hFF8, 8'd1, 3'd3, 2'b01);
        cmds[3] = mk(4'd6, 32'h100, 8'd1, 3'd2, 2'b11);
        cmds[4] = mk(4'd7, 32'h200, 8'd2, 3'd4, 2'b01);
        for (int k = 0; k < 5; k++) begin
            push_cmd(cmds[k]);
            collect_next(1);
            vectors++;
            if (beat_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL beat_count cmd %0d: extra beat, beat_valid=%b required 0", k, beat_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        tcmd_t       c;
        int          accepted, total;
        logic [54:0] act_t, exp_t;
        beat_ready = 1'b0;
        accepted   = 0;
        for (int i = 0; i < 6; i++) begin
            c = mk(4'(i + 8), ($urandom & 32'hFFFF_F000) | 32'h100, 8'($urandom_range(0, 3)),
                   3'($urandom_range(0, 3)), 2'b01);
            cmd_id = c.id; cmd_addr = c.addr; cmd_len = c.len; cmd_size = c.size; cmd_burst = c.burst;
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                accepted++;
                exp_q.push_back(c);
            end
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b0;
        vectors++;
        if ({accepted[3:0], cmd_ready, cmd_count} !== {4'd5, 1'b0, 3'd4}) begin
            miscompares++;
            $display("FAIL queue_full: accepted=%0d cmd_ready=%b cmd_count=%0d, required 5 0 4",
                     accepted, cmd_ready, cmd_count);
        end
        total = 0;
        foreach (exp_q[i]) total += int'(exp_q[i].len) + 1;
        beat_ready = 1'b1;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            for (int n = 0; n <= int'(c.len); n++) begin
                act_t = {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err};
                exp_t = model_beat(c, n);
                vectors++;
                if (act_t !== exp_t) begin
                    miscompares++;
                    $display("FAIL back_to_back id=%0d n=%0d: got %h required %h", c.id, n, act_t, exp_t);
                end
                @(posedge aclk); #1;
            end
        end
        beat_ready = 1'b0;
        vectors++;
        if ({beat_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL back_to_back_end after %0d beats: valid/busy=%b%b, required 00", total, beat_valid, busy);
        end
    endtask

    task automatic test_reset_midburst();
        push_cmd(mk(4'd1, 32'h2000, 8'd7, 3'd3, 2'b01));
        push_cmd(mk(4'd2, 32'h3000, 8'd1, 3'd2, 2'b01));
        push_cmd(mk(4'd3, 32'h4000, 8'd1, 3'd2, 2'b01));
        beat_ready = 1'b1;
        @(posedge aclk); #1;
        beat_ready = 1'b0;
        vectors++;
        if ({beat_valid, beat_idx, cmd_count} !== {1'b1, 8'd1, 3'd2}) begin
            miscompares++;
            $display("FAIL pre_reset: valid=%b idx=%0d count=%0d, required 1 1 2", beat_valid, beat_idx, cmd_count);
        end
        aresetn = 1'b0;
        #1;
        vectors++;
        if ({beat_valid, cmd_count, cmd_ready, busy} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b count=%0d ready=%b busy=%b, required 0 0 1 0",
                     beat_valid, cmd_count, cmd_ready, busy);
        end
        exp_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        push_cmd(mk(4'd9, 32'h5004, 8'd3, 3'd2, 2'b01));
        collect_next(0);
    endtask

    task automatic test_random();
        int k;
        for (int round = 0; round < 20; round++) begin
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) push_cmd(rand_cmd());
            for (int i = 0; i < k; i++) collect_next(2);
        end
        vectors++;
        if ({beat_valid, busy, cmd_count} !== {1'b0, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL random_end: valid=%b busy=%b count=%0d, required 0 0 0", beat_valid, busy, cmd_count);
        end
    endtask

    initial begin
        aresetn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_id     = 4'd0;
        cmd_addr   = 32'd0;
        cmd_len    = 8'd0;
        cmd_size   = 3'd0;
        cmd_burst  = 2'd0;
        beat_ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        test_reset();
        aresetn = 1'b1;
        @(posedge aclk); #1;
        test_reset();
        test_examples();
        test_fixed_and_illegal();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
